// File: rtl/video_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : video_timing_gen
// Purpose  : raster timing generator with pixel fetch strobe and 2-stage
//            output pipeline (hs, vs, de, color, frame_start).
// Option   : define VIDEO_TIMING_TESTPAT_EN to add test_mode (XOR pattern).
// Revision : 1.0
// ----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int unsigned H_VISIBLE   = 800,
  parameter int unsigned H_FRONT     = 40,
  parameter int unsigned H_SYNC      = 128,
  parameter int unsigned H_BACK      = 88,
  parameter int unsigned V_VISIBLE   = 600,
  parameter int unsigned V_FRONT     = 1,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BACK      = 23,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned CW          = 11,
  parameter logic [7:0]  BLANK_COLOR = 8'b11111100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
`ifdef VIDEO_TIMING_TESTPAT_EN
  input  logic          test_mode,
`endif
  output logic          fetch_req,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  input  logic [7:0]    pixel_in,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [7:0]    color,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL >= (64'd1 << CW)) begin : g_h_total_check
    $error("video_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (64'd1 << CW)) begin : g_v_total_check
    $error("video_timing_gen: V_TOTAL does not fit in CW bits");
  end

  // Stage 0: raster position
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  // Stage 1: fetch strobe plus sync/start tags travelling with it
  logic          fetch_req_q, fetch_req_d;
  logic [CW-1:0] fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, sof1_q, sof1_d;
  // Stage 2: output-aligned controls
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
  logic [7:0]    src_color;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end

    fetch_req_d = en && (h_q < H_VIS) && (v_q < V_VIS);
    fetch_x_d   = h_q;
    fetch_y_d   = v_q;
    // Sync levels follow the held position even while disabled.
    hs1_d  = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vs1_d  = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    sof1_d = en && (h_q == '0) && (v_q == '0);

    hs_d  = hs1_q;
    vs_d  = vs1_q;
    de_d  = fetch_req_q;
    sof_d = sof1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q         <= '0;
      v_q         <= '0;
      fetch_req_q <= 1'b0;
      fetch_x_q   <= '0;
      fetch_y_q   <= '0;
      hs1_q       <= ~HS_POL;
      vs1_q       <= ~VS_POL;
      sof1_q      <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      sof_q       <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      fetch_req_q <= fetch_req_d;
      fetch_x_q   <= fetch_x_d;
      fetch_y_q   <= fetch_y_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      sof1_q      <= sof1_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      sof_q       <= sof_d;
    end
  end

`ifdef VIDEO_TIMING_TESTPAT_EN
  logic [7:0] pat_q, pat_d;

  always_comb begin
    pat_d = 8'(fetch_x_q) ^ 8'(fetch_y_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  always_comb begin
    src_color = test_mode ? pat_q : pixel_in;
  end
`else
  always_comb begin
    src_color = pixel_in;
  end
`endif

  // pixel_in arrives in the same cycle the stage-2 controls become visible.
  always_comb begin
    color = de_q ? src_color : BLANK_COLOR;
  end

  assign fetch_req   = fetch_req_q;
  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = sof_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_video_timing_gen
// Purpose  : scoreboard bench for video_timing_gen on an 8x6 raster.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int CW = 11;
  localparam logic [7:0] BLANK = 8'hFC;

  logic          clk = 1'b0;
  logic          reset, en, tm;
  logic [7:0]    pixel_in;
  logic          fetch_req, hs, vs, de, frame_start;
  logic [CW-1:0] fetch_x, fetch_y;
  logic [7:0]    color;
  logic          fetch_req_n, hs_n, vs_n, de_n, frame_start_n;
  logic [CW-1:0] fetch_x_n, fetch_y_n;
  logic [7:0]    color_n;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  measure = 1'b0;
  int  mh = 0, mv = 0;

  typedef struct { int cyc; logic fr; logic [CW-1:0] fx, fy; } fexp_t;
  typedef struct { int cyc; logic hs, vs, de, fs; logic [7:0] color; } vexp_t;
  fexp_t fq[$];
  vexp_t vq[$];

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .BLANK_COLOR(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
`ifdef VIDEO_TIMING_TESTPAT_EN
    .test_mode(tm),
`endif
    .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .pixel_in(pixel_in), .hs(hs), .vs(vs), .de(de), .color(color),
    .frame_start(frame_start)
  );

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .BLANK_COLOR(BLANK)
  ) dut_n (
    .clk(clk), .reset(reset), .en(en),
`ifdef VIDEO_TIMING_TESTPAT_EN
    .test_mode(tm),
`endif
    .fetch_req(fetch_req_n), .fetch_x(fetch_x_n), .fetch_y(fetch_y_n),
    .pixel_in(pixel_in), .hs(hs_n), .vs(vs_n), .de(de_n), .color(color_n),
    .frame_start(frame_start_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rchk(input string tag);
    chk({tag, "_fetch_req"}, fetch_req, 1'b0);
    chk({tag, "_fetch_x"}, fetch_x, 0);
    chk({tag, "_fetch_y"}, fetch_y, 0);
    chk({tag, "_de"}, de, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_color"}, color, BLANK);
    chk({tag, "_hs"}, hs, 1'b0);
    chk({tag, "_vs"}, vs, 1'b0);
    chk({tag, "_hs_n"}, hs_n, 1'b1);
    chk({tag, "_vs_n"}, vs_n, 1'b1);
  endtask

  // Pixel memory: answers each fetch one cycle later; junk when idle.
  initial begin
    pixel_in = 8'h5A;
    forever begin
      @(negedge clk);
      pixel_in = fetch_req ? 8'(fetch_x + 16 * fetch_y) : 8'h5A;
    end
  end

  task automatic step(input logic rv, input logic ev);
    int k;
    fexp_t f;
    vexp_t v;
    logic vis;
    @(negedge clk);
    k = cyc;
    if (!rv && reset) begin
      reset = 1'b0;
      en    = ev;
      #1;
      rchk("async_reset");
      fq.delete();
      vq.delete();
      vq.push_back('{k + 1, 1'b0, 1'b0, 1'b0, 1'b0, BLANK});
      mh = 0;
      mv = 0;
    end
    reset = rv;
    en    = ev;
    if (!rv) begin
      fq.push_back('{k + 1, 1'b0, '0, '0});
      vq.push_back('{k + 2, 1'b0, 1'b0, 1'b0, 1'b0, BLANK});
    end else begin
      vis  = ev && (mh < 4) && (mv < 3);
      f    = '{k + 1, vis, CW'(mh), CW'(mv)};
      v.cyc   = k + 2;
      v.hs    = (mh >= 5) && (mh < 7);
      v.vs    = (mv == 4);
      v.de    = vis;
      v.fs    = ev && (mh == 0) && (mv == 0);
      v.color = !vis ? BLANK : (tm ? 8'(mh ^ mv) : 8'(mh + 16 * mv));
      fq.push_back(f);
      vq.push_back(v);
      if (ev) begin
        if (mh == 7) begin
          mh = 0;
          mv = (mv == 5) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
    end
  endtask

  // Monitor: pops expectations due this cycle and compares.
  initial begin
    fexp_t f;
    vexp_t v;
    bit armed = 1'b0;
    int per = 0, dec = 0, hsc = 0, vsc = 0;
    forever begin
      @(posedge clk);
      #1;
      while (fq.size() > 0 && fq[0].cyc < cyc) begin
        void'(fq.pop_front());
        chk("fetch_stale", 1, 0);
      end
      while (vq.size() > 0 && vq[0].cyc < cyc) begin
        void'(vq.pop_front());
        chk("video_stale", 1, 0);
      end
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        f = fq.pop_front();
        chk("fetch_req", fetch_req, f.fr);
        chk("fetch_x", fetch_x, f.fx);
        chk("fetch_y", fetch_y, f.fy);
        chk("fetch_req_n", fetch_req_n, f.fr);
        chk("fetch_xy_n", {fetch_x_n, fetch_y_n}, {f.fx, f.fy});
      end
      if (vq.size() > 0 && vq[0].cyc == cyc) begin
        v = vq.pop_front();
        chk("hs", hs, v.hs);
        chk("vs", vs, v.vs);
        chk("de", de, v.de);
        chk("frame_start", frame_start, v.fs);
        chk("color", color, v.color);
        chk("hs_n", hs_n, !v.hs);
        chk("vs_n", vs_n, !v.vs);
        chk("de_fs_n", {de_n, frame_start_n}, {v.de, v.fs});
        chk("color_n", color_n, v.color);
      end
      if (frame_start === 1'b1) begin
        if (armed) begin
          chk("frame_period", per, 48);
          chk("de_per_frame", dec, 12);
          chk("hs_per_frame", hsc, 12);
          chk("vs_per_frame", vsc, 8);
        end
        armed = measure;
        per = 0; dec = 0; hsc = 0; vsc = 0;
      end
      per++;
      dec += int'(de === 1'b1);
      hsc += int'(hs === 1'b1);
      vsc += int'(vs === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    tm    = 1'b0;
    #2 reset = 1'b0;
    #1 rchk("por");
    repeat (3) step(1'b0, 1'b1);
    measure = 1'b1;
    repeat (140) step(1'b1, 1'b1);
    measure = 1'b0;
    // Hold the raster at (2,1) for five cycles.
    while (!(mh == 2 && mv == 1)) step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1);
    // Reset in mid-frame at (3,2), then a delayed enable after release.
    while (!(mh == 3 && mv == 2)) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (60) step(1'b1, 1'b1);
`ifdef VIDEO_TIMING_TESTPAT_EN
    step(1'b0, 1'b1);
    tm = 1'b1;
    step(1'b0, 1'b1);
    repeat (60) step(1'b1, 1'b1);
`endif
    repeat (4) @(negedge clk);
    chk("queue_drained", fq.size() + vq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
